// File: rtl/register_file.sv
// register_file: 64 x 16-bit general-purpose register file for the highRISC datapath.
// Two combinational read ports (A, B) and one synchronous write port.
// The write port shares its address with read port A.
// Register 0 is hardwired to zero.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] AddressA,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] AddressB,
  output logic [DATA_WIDTH-1:0] ReadDataB
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic                  w_writeHit;
  logic                  w_aIsZero;
  logic                  w_bIsZero;

  // A write only lands when enabled and aimed at a real (nonzero) register.
  assign w_writeHit = WriteEnable && (AddressA != '0);

  // Address 0 is detected on each port so it can be forced to read as zero.
  assign w_aIsZero  = (AddressA == '0);
  assign w_bIsZero  = (AddressB == '0);

  // Storage update: reset clears everything and beats a same-cycle write.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeHit) begin
      r_regs[AddressA] <= WriteData;
    end
  end

  // Read ports: purely combinational, no bypass, register 0 always zero.
  always_comb begin
    ReadDataA = '0;
    ReadDataB = '0;
    if (!w_aIsZero) begin
      ReadDataA = r_regs[AddressA];
    end
    if (!w_bIsZero) begin
      ReadDataB = r_regs[AddressB];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
// Each scenario is a task with inline comparisons; all run from one initial block.
module tb_register_file;

  logic        Clock;
  logic        Reset;
  logic [5:0]  AddressA;
  logic [15:0] ReadDataA;
  logic [15:0] WriteData;
  logic        WriteEnable;
  logic [5:0]  AddressB;
  logic [15:0] ReadDataB;

  int errorCount;
  int checkCount;

  register_file #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(6)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .AddressA   (AddressA),
    .ReadDataA  (ReadDataA),
    .WriteData  (WriteData),
    .WriteEnable(WriteEnable),
    .AddressB   (AddressB),
    .ReadDataB  (ReadDataB)
  );

  // Free-running 10-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Advance past one rising edge and let the outputs settle.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    AddressA    = 6'd5;
    AddressB    = 6'd63;
    WriteEnable = 1'b0;
    WriteData   = 16'h0000;
    Reset       = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    checkCount++;
    if (ReadDataA !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_portA got=%h exp=%h", ReadDataA, 16'h0000);
    end
    checkCount++;
    if (ReadDataB !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_portB got=%h exp=%h", ReadDataB, 16'h0000);
    end
    for (int i = 0; i < 64; i++) begin
      AddressA = 6'(i);
      AddressB = 6'(63 - i);
      #1;
      checkCount++;
      if (ReadDataA !== 16'h0000 || ReadDataB !== 16'h0000) begin
        errorCount++;
        $display("[TB] FAIL reset_sweep addr=%0d got A=%h B=%h exp=0000", i, ReadDataA, ReadDataB);
      end
    end
  endtask

  task automatic test_basic_write();
    AddressA    = 6'd10;
    AddressB    = 6'd10;
    WriteData   = 16'hBEEF;
    WriteEnable = 1'b1;
    #1;
    checkCount++;
    if (ReadDataA !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL no_bypass got=%h exp=%h", ReadDataA, 16'h0000);
    end
    tick();
    WriteEnable = 1'b0;
    #1;
    checkCount++;
    if (ReadDataA !== 16'hBEEF) begin
      errorCount++;
      $display("[TB] FAIL basic_portA got=%h exp=%h", ReadDataA, 16'hBEEF);
    end
    checkCount++;
    if (ReadDataB !== 16'hBEEF) begin
      errorCount++;
      $display("[TB] FAIL basic_portB got=%h exp=%h", ReadDataB, 16'hBEEF);
    end
  endtask

  task automatic test_reg0_and_portb();
    AddressA    = 6'd0;
    WriteData   = 16'h1234;
    WriteEnable = 1'b1;
    tick();
    WriteEnable = 1'b0;
    #1;
    checkCount++;
    if (ReadDataA !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reg0_write got=%h exp=%h", ReadDataA, 16'h0000);
    end
    AddressA    = 6'd63;
    WriteData   = 16'hA5A5;
    WriteEnable = 1'b1;
    AddressB    = 6'd10;
    #1;
    checkCount++;
    if (ReadDataB !== 16'hBEEF) begin
      errorCount++;
      $display("[TB] FAIL portB_before_write got=%h exp=%h", ReadDataB, 16'hBEEF);
    end
    tick();
    WriteEnable = 1'b0;
    checkCount++;
    if (ReadDataB !== 16'hBEEF) begin
      errorCount++;
      $display("[TB] FAIL portB_after_write got=%h exp=%h", ReadDataB, 16'hBEEF);
    end
    AddressB = 6'd63;
    #1;
    checkCount++;
    if (ReadDataB !== 16'hA5A5) begin
      errorCount++;
      $display("[TB] FAIL portB_reg63 got=%h exp=%h", ReadDataB, 16'hA5A5);
    end
    checkCount++;
    if (ReadDataA !== 16'hA5A5) begin
      errorCount++;
      $display("[TB] FAIL portA_reg63 got=%h exp=%h", ReadDataA, 16'hA5A5);
    end
  endtask

  task automatic test_write_enable_gating();
    AddressA    = 6'd20;
    WriteData   = 16'hFFFF;
    WriteEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    checkCount++;
    if (ReadDataA !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL we_gating got=%h exp=%h", ReadDataA, 16'h0000);
    end
  endtask

  task automatic test_fill();
    logic [15:0] expA;
    logic [15:0] expB;
    for (int i = 1; i < 64; i++) begin
      AddressA    = 6'(i);
      WriteData   = 16'(i);
      WriteEnable = 1'b1;
      tick();
    end
    WriteEnable = 1'b0;
    for (int i = 0; i < 64; i++) begin
      AddressA = 6'(i);
      AddressB = 6'(63 - i);
      expA     = 16'(i);
      expB     = 16'(63 - i);
      #1;
      checkCount++;
      if (ReadDataA !== expA || ReadDataB !== expB) begin
        errorCount++;
        $display("[TB] FAIL fill_cross i=%0d got A=%h B=%h exp A=%h B=%h", i, ReadDataA, ReadDataB, expA, expB);
      end
    end
    for (int i = 63; i >= 0; i--) begin
      AddressA = 6'(i);
      AddressB = 6'(i);
      expA     = 16'(i);
      #1;
      checkCount++;
      if (ReadDataA !== expA || ReadDataB !== expA) begin
        errorCount++;
        $display("[TB] FAIL fill_same i=%0d got A=%h B=%h exp=%h", i, ReadDataA, ReadDataB, expA);
      end
    end
  endtask

  task automatic test_reset_priority();
    AddressA    = 6'd7;
    WriteData   = 16'h5555;
    WriteEnable = 1'b1;
    Reset       = 1'b1;
    AddressB    = 6'd10;
    #1;
    checkCount++;
    if (ReadDataB !== 16'h000A) begin
      errorCount++;
      $display("[TB] FAIL pre_reset_reg10 got=%h exp=%h", ReadDataB, 16'h000A);
    end
    tick();
    Reset       = 1'b0;
    WriteEnable = 1'b0;
    #1;
    checkCount++;
    if (ReadDataA !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_prio_reg7 got=%h exp=%h", ReadDataA, 16'h0000);
    end
    checkCount++;
    if (ReadDataB !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_prio_reg10 got=%h exp=%h", ReadDataB, 16'h0000);
    end
    AddressA = 6'd63;
    #1;
    checkCount++;
    if (ReadDataA !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_prio_reg63 got=%h exp=%h", ReadDataA, 16'h0000);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    errorCount  = 0;
    checkCount  = 0;
    Reset       = 1'b0;
    AddressA    = '0;
    AddressB    = '0;
    WriteData   = '0;
    WriteEnable = 1'b0;
    @(negedge Clock);
    test_reset();
    test_basic_write();
    test_reg0_and_portb();
    test_write_enable_gating();
    test_fill();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
